// File: rtl/ora_pkg.sv
// Shared types for the ORA golden-response sequencer: FSM states and memory RW encoding.
package ora_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN_FETCH = 2'd1,
        RUN_WAIT  = 2'd2,
        DONE      = 2'd3
    } ora_state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/ora_cmp.sv
// Golden/response comparator with saturating mismatch counter.
// Optional first-fail address capture when ORA_FIRST_FAIL_EN is defined.
module ora_cmp
    import ora_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 cmp_en,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic [ADDR_BITS-1:0] idx,
`ifdef ORA_FIRST_FAIL_EN
    output logic [ADDR_BITS-1:0] first_fail_addr,
    output logic                 first_fail_valid,
`endif
    output logic [ADDR_BITS:0]   fail_count
);

    localparam logic [ADDR_BITS:0] CNT_ONE = 1;

    logic               w_mismatch;
    logic               w_saturated;
    logic [ADDR_BITS:0] r_fail_count;

    assign w_mismatch  = cmp_en && (a != b);
    assign w_saturated = &r_fail_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fail_count <= '0;
        end else if (clr) begin
            r_fail_count <= '0;
        end else if (w_mismatch && !w_saturated) begin
            r_fail_count <= r_fail_count + CNT_ONE;
        end
    end

    assign fail_count = r_fail_count;

`ifdef ORA_FIRST_FAIL_EN
    logic [ADDR_BITS-1:0] r_first_addr;
    logic                 r_first_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first_addr  <= '0;
            r_first_valid <= 1'b0;
        end else if (clr) begin
            r_first_addr  <= '0;
            r_first_valid <= 1'b0;
        end else if (w_mismatch && !r_first_valid) begin
            r_first_addr  <= idx;
            r_first_valid <= 1'b1;
        end
    end

    assign first_fail_addr  = r_first_addr;
    assign first_fail_valid = r_first_valid;
`else
    logic w_unused_idx;
    assign w_unused_idx = ^idx;
`endif

endmodule

// File: rtl/ora_ctrl.sv
// LBIST ORA sequencer: loads golden words in IDLE, then walks the memory comparing against CUT responses.
// Define ORA_FIRST_FAIL_EN to add first_fail_addr/first_fail_valid outputs.
module ora_ctrl
    import ora_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 clear,
    input  logic [ADDR_BITS:0]   num_patterns,
    input  logic                 load_valid,
    input  logic                 load_rst,
    input  logic [WORD_SIZE-1:0] load_data,
    input  logic                 resp_valid,
    input  logic [WORD_SIZE-1:0] resp_data,
    output logic                 resp_ready,
    output logic                 mem_en,
    output logic                 mem_rw,
    output logic [ADDR_BITS-1:0] mem_add,
    output logic [WORD_SIZE-1:0] mem_data_w,
    input  logic [WORD_SIZE-1:0] mem_data_r,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
`ifdef ORA_FIRST_FAIL_EN
    output logic [ADDR_BITS-1:0] first_fail_addr,
    output logic                 first_fail_valid,
`endif
    output logic [ADDR_BITS:0]   fail_count
);

    localparam logic [ADDR_BITS:0]   IDX_ONE = 1;
    localparam logic [ADDR_BITS-1:0] LP_ONE  = 1;

    ora_state_t           r_state;
    ora_state_t           w_next_state;
    logic [ADDR_BITS:0]   r_idx;
    logic [ADDR_BITS:0]   r_n;
    logic [ADDR_BITS-1:0] r_lp;
    logic                 w_start_acc;
    logic                 w_resp_take;
    logic                 w_last;
    logic                 w_write;

    assign w_start_acc = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_resp_take = (r_state == RUN_WAIT) && resp_valid;
    // r_n is never zero in the RUN states, so N-1 cannot underflow here
    assign w_last      = (r_idx == (r_n - IDX_ONE));
    assign w_write     = (r_state == IDLE) && load_valid && !load_rst && !start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next_state = (num_patterns == '0) ? DONE : RUN_FETCH;
                end else if (clear && (r_state == DONE)) begin
                    w_next_state = IDLE;
                end
            end
            RUN_FETCH: w_next_state = RUN_WAIT;
            RUN_WAIT: begin
                if (resp_valid) begin
                    w_next_state = w_last ? DONE : RUN_FETCH;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        resp_ready = 1'b0;
        mem_en     = 1'b0;
        mem_rw     = MEM_READ;
        mem_add    = '0;
        mem_data_w = '0;
        case (r_state)
            IDLE: begin
                if (w_write) begin
                    mem_en     = 1'b1;
                    mem_rw     = MEM_WRITE;
                    mem_add    = r_lp;
                    mem_data_w = load_data;
                end
            end
            RUN_FETCH: begin
                busy    = 1'b1;
                mem_en  = 1'b1;
                mem_rw  = MEM_READ;
                mem_add = r_idx[ADDR_BITS-1:0];
            end
            RUN_WAIT: begin
                busy       = 1'b1;
                resp_ready = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                pass = (fail_count == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_n   <= '0;
            r_lp  <= '0;
        end else begin
            if (w_start_acc) begin
                r_idx <= '0;
                r_n   <= num_patterns;
            end else if (w_resp_take && !w_last) begin
                r_idx <= r_idx + IDX_ONE;
            end
            if (r_state == IDLE) begin
                if (load_rst) begin
                    r_lp <= '0;
                end else if (w_write) begin
                    r_lp <= r_lp + LP_ONE;
                end
            end
        end
    end

    ora_cmp #(
        .WORD_SIZE (WORD_SIZE),
        .ADDR_BITS (ADDR_BITS)
    ) u_cmp (
        .clk              (clk),
        .rst              (rst),
        .clr              (w_start_acc),
        .cmp_en           (w_resp_take),
        .a                (resp_data),
        .b                (mem_data_r),
        .idx              (r_idx[ADDR_BITS-1:0]),
`ifdef ORA_FIRST_FAIL_EN
        .first_fail_addr  (first_fail_addr),
        .first_fail_valid (first_fail_valid),
`endif
        .fail_count       (fail_count)
    );

endmodule
